// File: rtl/crc_serial_engine_pkg.sv
// Shared types and helpers for the serial CRC engine: FSM states, default
// polynomial/seed, and the single-bit LFSR step.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OUT,
    REPORT
  } state_t;

  localparam logic [7:0] DEF_POLY = 8'h44;
  localparam logic [7:0] DEF_SEED = 8'hD8;

  // One LSB-first Galois step on the low `width` bits; upper bits return 0.
  function automatic logic [31:0] crc_step(input logic [31:0] lfsr,
                                           input logic [31:0] poly,
                                           input int unsigned width,
                                           input logic        din);
    logic        fb;
    logic [31:0] low_mask;
    logic [31:0] nxt;
    fb       = din ^ lfsr[0];
    low_mask = (32'd1 << (width - 1)) - 32'd1;
    nxt      = ((lfsr >> 1) ^ ({32{fb}} & poly)) & low_mask;
    nxt      = nxt | ({31'b0, fb} << (width - 1));
    return nxt;
  endfunction

endpackage

// File: rtl/crc_serial_engine_if.sv
// Serial frame / CRC bundle between the framer side and the CRC engine.
interface crc_serial_engine_if #(
  parameter int unsigned LEN_W = 16
);
  logic             DATA;
  logic             ACTIVE;
  logic             MODE;
  logic             CRC;
  logic             Valid;
  logic             Done;
  logic             Error;
  logic             Busy;
  logic [LEN_W-1:0] Len;

  modport master (
    output DATA, ACTIVE, MODE,
    input  CRC, Valid, Done, Error, Busy, Len
  );

  modport slave (
    input  DATA, ACTIVE, MODE,
    output CRC, Valid, Done, Error, Busy, Len
  );
endinterface

// File: rtl/crc_serial_engine_lfsr_core.sv
// CRC remainder register: seed load, data step (optionally from the seed in
// the same cycle) and zero-filled right shift for serial readout.
module crc_lfsr_core
  import crc_pkg::*;
#(
  parameter int unsigned          CRC_W = 8,
  parameter logic [CRC_W-1:0]     POLY  = CRC_W'(DEF_POLY),
  parameter logic [CRC_W-1:0]     SEED  = CRC_W'(DEF_SEED)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_seed,
  input  logic step_en,
  input  logic shift_en,
  input  logic din,
  output logic lsb,
  output logic zero
);

  logic [CRC_W-1:0] lfsr_q;
  logic [CRC_W-1:0] lfsr_d;
  logic [CRC_W-1:0] step_base;
  logic [31:0]      stepped;

  // load_seed together with step_en steps from SEED, not from the old remainder.
  always_comb begin
    step_base = load_seed ? SEED : lfsr_q;
    stepped   = crc_step(32'(step_base), 32'(POLY), CRC_W, din);
    lfsr_d    = lfsr_q;
    if (step_en) begin
      lfsr_d = stepped[CRC_W-1:0];
    end else if (shift_en) begin
      lfsr_d = lfsr_q >> 1;
    end else if (load_seed) begin
      lfsr_d = SEED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lsb  = lfsr_q[0];
  assign zero = (lfsr_q == '0);

endmodule

// File: rtl/crc_serial_engine.sv
// Serial CRC engine: generates and shifts out a frame CRC, or checks a frame
// with its appended CRC and reports pass/fail.
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(DEF_POLY),
  parameter logic [CRC_W-1:0] SEED  = CRC_W'(DEF_SEED),
  parameter int unsigned      LEN_W = 16
) (
  input  logic                CLK,
  input  logic                RST,
  crc_serial_engine_if.slave  bus
);

  localparam int unsigned      CNT_W    = $clog2(CRC_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic             error_q, error_d;

  logic load_seed;
  logic step_en;
  logic shift_en;
  logic start;
  logic lfsr_lsb;
  logic lfsr_zero;
  logic valid;

  crc_lfsr_core #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk       (CLK),
    .rst_n     (RST),
    .load_seed (load_seed),
    .step_en   (step_en),
    .shift_en  (shift_en),
    .din       (bus.DATA),
    .lsb       (lfsr_lsb),
    .zero      (lfsr_zero)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      error_q <= error_d;
    end
  end

  // Any ACTIVE outside SHIFT starts a frame; this also covers abort in OUT
  // and back-to-back start in REPORT after the per-state work below.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    mode_d    = mode_q;
    error_d   = error_q;
    load_seed = 1'b0;
    step_en   = 1'b0;
    shift_en  = 1'b0;
    start     = bus.ACTIVE && (state_q != SHIFT);

    case (state_q)
      SHIFT: begin
        if (bus.ACTIVE) begin
          step_en = 1'b1;
          if (len_q != '1) len_d = len_q + 1'b1;
        end else begin
          state_d = mode_q ? REPORT : OUT;
          cnt_d   = '0;
        end
      end
      OUT: begin
        if (!bus.ACTIVE) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = IDLE;
        end
      end
      REPORT: begin
        error_d = !lfsr_zero;
        if (!bus.ACTIVE) begin
          load_seed = 1'b1;
          state_d   = IDLE;
        end
      end
      default: ;
    endcase

    if (start) begin
      load_seed = 1'b1;
      step_en   = 1'b1;
      mode_d    = bus.MODE;
      len_d     = LEN_W'(1);
      state_d   = SHIFT;
    end
  end

  always_comb begin
    valid     = (state_q == OUT) && !bus.ACTIVE;
    bus.Valid = valid;
    bus.CRC   = valid && lfsr_lsb;
    bus.Done  = (state_q == REPORT);
    bus.Error = (state_q == REPORT) ? !lfsr_zero : error_q;
    bus.Busy  = (state_q == SHIFT) || (state_q == OUT);
    bus.Len   = len_q;
  end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Drives three engine configurations with identical serial stimulus and
// checks each against a bit-list CRC reference.
module tb_crc_serial_engine;

  typedef struct {
    logic        crc;
    logic        valid;
    logic        done;
    logic        err;
    logic        busy;
    logic [31:0] len;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic data;
  logic active;
  logic mode;

  always #5 clk = ~clk;

  crc_serial_engine_if #(.LEN_W(16)) bus_a ();
  crc_serial_engine_if #(.LEN_W(16)) bus_z ();
  crc_serial_engine_if #(.LEN_W(4))  bus_w ();

  assign bus_a.DATA = data;  assign bus_a.ACTIVE = active;  assign bus_a.MODE = mode;
  assign bus_z.DATA = data;  assign bus_z.ACTIVE = active;  assign bus_z.MODE = mode;
  assign bus_w.DATA = data;  assign bus_w.ACTIVE = active;  assign bus_w.MODE = mode;

  crc_serial_engine #(.CRC_W(8), .POLY(8'h44), .SEED(8'hD8), .LEN_W(16)) u_a (
    .CLK(clk), .RST(rst_n), .bus(bus_a.slave));
  crc_serial_engine #(.CRC_W(8), .POLY(8'h44), .SEED(8'h00), .LEN_W(16)) u_z (
    .CLK(clk), .RST(rst_n), .bus(bus_z.slave));
  crc_serial_engine #(.CRC_W(16), .POLY(16'h1021), .SEED(16'hFFFF), .LEN_W(4)) u_w (
    .CLK(clk), .RST(rst_n), .bus(bus_w.slave));

  int unsigned cw[3]   = '{8, 8, 16};
  logic [31:0] cp[3]   = '{32'h44, 32'h44, 32'h1021};
  logic [31:0] cs[3]   = '{32'hD8, 32'h00, 32'hFFFF};
  int unsigned lmax[3] = '{65535, 65535, 15};

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] obs_bits[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic obs_t outs(input int k);
    obs_t o;
    case (k)
      0: begin o.crc = bus_a.CRC; o.valid = bus_a.Valid; o.done = bus_a.Done;
               o.err = bus_a.Error; o.busy = bus_a.Busy; o.len = 32'(bus_a.Len); end
      1: begin o.crc = bus_z.CRC; o.valid = bus_z.Valid; o.done = bus_z.Done;
               o.err = bus_z.Error; o.busy = bus_z.Busy; o.len = 32'(bus_z.Len); end
      default: begin o.crc = bus_w.CRC; o.valid = bus_w.Valid; o.done = bus_w.Done;
               o.err = bus_w.Error; o.busy = bus_w.Busy; o.len = 32'(bus_w.Len); end
    endcase
    return o;
  endfunction

  // Remainder as a bit array, updated literally stage by stage.
  function automatic logic [31:0] ref_crc(input int k, input bit bits[$]);
    bit          r[32];
    bit          nx[32];
    bit          fb;
    logic [31:0] res;
    for (int i = 0; i < 32; i++) r[i] = cs[k][i];
    foreach (bits[n]) begin
      fb = bits[n] ^ r[0];
      for (int i = 0; i < 32; i++) nx[i] = 1'b0;
      for (int i = 0; i < int'(cw[k]) - 1; i++) nx[i] = r[i+1] ^ (fb & cp[k][i]);
      nx[cw[k]-1] = fb;
      r = nx;
    end
    res = '0;
    for (int i = 0; i < int'(cw[k]); i++) res[i] = r[i];
    return res;
  endfunction

  function automatic int unsigned sat_len(input int k, input int unsigned n);
    return (n > lmax[k]) ? lmax[k] : n;
  endfunction

  function automatic void rand_frame(input int n, output bit q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(bit'($urandom_range(0, 1)));
  endfunction

  task automatic reset_check(input string tag);
    obs_t o;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      o = outs(k);
      chk($sformatf("%s_crc[%0d]", tag, k),   32'(o.crc),   0);
      chk($sformatf("%s_valid[%0d]", tag, k), 32'(o.valid), 0);
      chk($sformatf("%s_done[%0d]", tag, k),  32'(o.done),  0);
      chk($sformatf("%s_err[%0d]", tag, k),   32'(o.err),   0);
      chk($sformatf("%s_busy[%0d]", tag, k),  32'(o.busy),  0);
      chk($sformatf("%s_len[%0d]", tag, k),   o.len,        0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    active = 1'b0;
    data   = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic drive_frame(input bit q[$], input logic m, input int first);
    obs_t o;
    for (int i = first; i < q.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        for (int k = 0; k < 3; k++) begin
          o = outs(k);
          chk($sformatf("shift_busy[%0d]", k), 32'(o.busy), 1);
          chk($sformatf("shift_len[%0d]", k), o.len, sat_len(k, i));
        end
      end
      active = 1'b1;
      data   = q[i];
      mode   = (i == 0) ? m : logic'($urandom_range(0, 1));
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      o = outs(k);
      chk($sformatf("last_busy[%0d]", k), 32'(o.busy), 1);
    end
    active = 1'b0;
    data   = logic'($urandom_range(0, 1));
    mode   = logic'($urandom_range(0, 1));
  endtask

  task automatic out_phase(input bit q[$]);
    obs_t        o;
    logic [31:0] r[3];
    logic        ev;
    for (int k = 0; k < 3; k++) begin
      r[k]        = ref_crc(k, q);
      obs_bits[k] = '0;
    end
    for (int j = 0; j <= 16; j++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        o  = outs(k);
        ev = (j < int'(cw[k]));
        chk($sformatf("out_valid[%0d] j%0d", k, j), 32'(o.valid), 32'(ev));
        chk($sformatf("out_crc[%0d] j%0d", k, j), 32'(o.crc), ev ? 32'(r[k][j]) : 0);
        chk($sformatf("out_busy[%0d] j%0d", k, j), 32'(o.busy), 32'(ev));
        if (j == 0) chk($sformatf("out_done[%0d]", k), 32'(o.done), 0);
        if (j < 32) obs_bits[k][j] = o.crc;
      end
    end
    for (int k = 0; k < 3; k++) begin
      o = outs(k);
      chk($sformatf("out_len[%0d]", k), o.len, sat_len(k, q.size()));
    end
  endtask

  task automatic gen_frame(input bit q[$]);
    drive_frame(q, 1'b0, 0);
    out_phase(q);
  endtask

  task automatic check_frame(input bit q[$], input int must_pass);
    obs_t o;
    logic e[3];
    drive_frame(q, 1'b1, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      o    = outs(k);
      e[k] = (ref_crc(k, q) != 0);
      chk($sformatf("rep_done[%0d]", k), 32'(o.done), 1);
      chk($sformatf("rep_err[%0d]", k), 32'(o.err), 32'(e[k]));
      if (k == must_pass) chk($sformatf("rep_pass[%0d]", k), 32'(o.err), 0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      o = outs(k);
      chk($sformatf("post_done[%0d]", k), 32'(o.done), 0);
      chk($sformatf("held_err[%0d]", k), 32'(o.err), 32'(e[k]));
      chk($sformatf("post_busy[%0d]", k), 32'(o.busy), 0);
      chk($sformatf("post_len[%0d]", k), o.len, sat_len(k, q.size()));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          q[$];
    bit          q2[$];
    bit          d[$];
    logic [31:0] c;
    int          k0;
    int          pos;
    obs_t        o;

    active = 1'b0;
    data   = 1'b0;
    mode   = 1'b0;
    #3;
    reset_check("reset");
    release_reset();

    q = {1'b1};
    gen_frame(q);
    chk("seed0_vector", obs_bits[1] & 32'hFF, 32'hC4);

    for (int t = 0; t < 10; t++) begin
      rand_frame(8, q);
      gen_frame(q);
    end
    rand_frame(20, q);
    gen_frame(q);

    for (int t = 0; t < 6; t++) begin
      rand_frame(8 + (t * 3), d);
      k0 = (t % 2 == 1) ? 2 : 0;
      c  = ref_crc(k0, d);
      q  = d;
      for (int i = 0; i < int'(cw[k0]); i++) q.push_back(c[i]);
      check_frame(q, k0);
      pos    = $urandom_range(0, d.size() - 1);
      q[pos] = ~q[pos];
      check_frame(q, -1);
    end

    rand_frame(5, q);
    drive_frame(q, 1'b0, 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        o = outs(k);
        chk($sformatf("pre_abort_valid[%0d] j%0d", k, j), 32'(o.valid), 1);
      end
    end
    rand_frame(7, q2);
    active = 1'b1;
    data   = q2[0];
    mode   = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      o = outs(k);
      chk($sformatf("abort_valid[%0d]", k), 32'(o.valid), 0);
      chk($sformatf("abort_crc[%0d]", k), 32'(o.crc), 0);
    end
    drive_frame(q2, 1'b0, 1);
    out_phase(q2);

    rand_frame(10, q);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      active = 1'b1;
      data   = q[i];
      mode   = 1'b1;
    end
    @(negedge clk);
    #2;
    reset_check("rst_shift");
    release_reset();
    rand_frame(9, q);
    gen_frame(q);

    rand_frame(6, q);
    drive_frame(q, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      o = outs(k);
      chk($sformatf("pre_rst_valid[%0d]", k), 32'(o.valid), 1);
    end
    #2;
    reset_check("rst_out");
    release_reset();
    rand_frame(11, q);
    gen_frame(q);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
